au_arbiter: RTL and testbench
=============================

Name: au_arbiter

Overview:
- Shares one 16-bit adder unit (instance of `au`: sum plus sign, zero, carry, parity and overflow flags) between two requesters.
- Round-robin arbitration; operands are registered, the add is issued, and the sum and flags are captured.
- Results return over a single response channel with a valid/ready handshake, tagged with the requester ID.
- Sits between the two ALU-issuing masters and the shared adder.

Parameters:
- WIDTH, 16, operand/result width (au is 16-bit; the only supported value is 16)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  2  per-requester request, level; held until matching ack
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- a1  input  WIDTH  requester 1 operand A
- b1  input  WIDTH  requester 1 operand B
- ack  output  2  one-cycle pulse: operands of that requester captured
- rsp_valid  output  1  response holds a result
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester the response belongs to
- c  output  WIDTH  registered sum
- s  output  1  registered sign flag (c[15])
- zr  output  1  registered zero flag (c == 0)
- cy  output  1  registered carry-out of the 16-bit add
- p  output  1  registered parity flag, 1 when c has an even number of ones
- v  output  1  registered signed overflow flag
- busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset, asynchronous on rst high:
  - State goes to IDLE.
  - ack, rsp_valid, rsp_id, c, s, zr, cy, p and v all go to 0.
  - The priority pointer goes to 0, so requester 0 is favoured first.
- State machine: IDLE, EXEC, RESP.
- IDLE:
  - No req bit set: stay in IDLE.
  - Exactly one req bit set: that requester is granted.
  - Both req bits set: the requester named by the priority pointer is granted.
  - On the granting edge: latch the granted a/b into internal op registers, latch grant ID, go to EXEC.
- EXEC, exactly 1 cycle:
  - ack[ID] = 1 for this cycle only.
  - The au instance is driven from the op registers.
  - The au sum and flags are captured into c/s/zr/cy/p/v at the end of the cycle.
  - rsp_id is set to ID; go to RESP.
- RESP:
  - rsp_valid = 1; c, flags and rsp_id are held stable.
  - On rsp_valid && rsp_ready: priority pointer = ~ID; go to IDLE; rsp_valid drops next cycle.
  - Outputs keep their last values after the response is consumed.
- Latency:
  - req seen at edge N gives ack high during cycle N+1.
  - rsp_valid is high from cycle N+2.
  - Best-case throughput is one operation per 3 cycles while rsp_ready is held high.
- Requester contract:
  - Operands must stay stable and req must stay asserted until ack is seen.
  - req deasserted before grant is simply not served.
  - A requester may re-assert req in the cycle after its ack; it is arbitrated fresh once the block returns to IDLE.
- Backpressure: rsp_ready low holds RESP indefinitely; no new request is accepted and req stays pending.
- Fairness: with both req held continuously, grants alternate 0,1,0,1… starting from the reset pointer.
- Arithmetic, done inside au and not re-implemented:
  - Sum is taken mod 2^16.
  - cy = carry out of bit 15.
  - v = (a[15] == b[15]) && (c[15] != a[15]).
- Reset mid-operation, in any state: abort immediately, and the in-flight result is discarded with no ack or rsp.

Decomposition:
- Shared package (au_pkg) holds:
  - state encoding constants: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2
  - WIDTH = 16
  - requester ID constants
- Sub-module: `au`, the existing adder unit, instantiated once.
- Arbitration (pointer plus grant logic) may live in a small sub-module rr_arb2; it is optional.

Test Plan:
- Reset then idle, with rst pulsed mid-cycle → all outputs 0, busy = 0 with no clock edge needed.
- req = 01, a0 = 8fff, b0 = 8000, rsp_ready = 1:
  - ack = 01 one cycle later.
  - Then rsp_valid = 1, rsp_id = 0, c = 0fff, s = 0, zr = 0, cy = 1, p = 1, v = 1.
- req = 10, a1 = fffe, b1 = 0002 → rsp_id = 1, c = 0000, zr = 1, cy = 1, s = 0, p = 1, v = 0.
- Both req held:
  - a0 = AAAA, b0 = 5555, a1 = 0001, b1 = 0001.
  - Expected responses in order: ID 0 with c = ffff, s = 1, cy = 0, p = 1, v = 0; then ID 1 with c = 0002, p = 0; then ID 0 again (alternation check).
- rsp_ready held low for 5 cycles in RESP:
  - rsp_valid, c and flags stay stable; busy = 1; the pending req gets no ack.
  - Raise rsp_ready: handshake completes and the next grant follows.
- rst asserted during EXEC → no response ever appears for that request; after release, priority is back to requester 0.

Source files
------------

// File: rtl/au_pkg.sv
// Shared definitions for the shared-adder arbiter slice: datapath width,
// FSM state encoding, requester IDs and the adder flag bundle.
package au_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    typedef struct packed {
        logic s;
        logic zr;
        logic cy;
        logic p;
        logic v;
    } flags_t;

endpackage

// File: rtl/au_arbiter_if.sv
// Bundle of the request, operand and response signals between the two
// ALU-issuing masters and the arbiter. The slave side is the arbiter.
interface au_arbiter_if;

    logic [1:0]                req;
    logic [au_pkg::WIDTH-1:0]  a0;
    logic [au_pkg::WIDTH-1:0]  b0;
    logic [au_pkg::WIDTH-1:0]  a1;
    logic [au_pkg::WIDTH-1:0]  b1;
    logic [1:0]                ack;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      rsp_id;
    logic [au_pkg::WIDTH-1:0]  c;
    logic                      s;
    logic                      zr;
    logic                      cy;
    logic                      p;
    logic                      v;
    logic                      busy;

    modport master (
        output req, a0, b0, a1, b1, rsp_ready,
        input  ack, rsp_valid, rsp_id, c, s, zr, cy, p, v, busy
    );

    modport slave (
        input  req, a0, b0, a1, b1, rsp_ready,
        output ack, rsp_valid, rsp_id, c, s, zr, cy, p, v, busy
    );

endinterface

// File: rtl/au.sv
// Existing 16-bit adder unit: purely combinational sum plus sign, zero,
// carry, even-parity and signed-overflow flags.
module au
    import au_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output flags_t           flags
);

    logic [WIDTH:0] sum;

    // One extra bit on the add exposes the carry out of the top bit
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        c        = sum[WIDTH-1:0];
        flags.s  = sum[WIDTH-1];
        flags.zr = (sum[WIDTH-1:0] == '0);
        flags.cy = sum[WIDTH];
        flags.p  = ~^sum[WIDTH-1:0];
        flags.v  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/au_arbiter.sv
// Round-robin arbiter sharing one adder unit between two requesters.
// A grant latches operands, the add runs for one cycle, and the result
// is offered on a valid/ready response channel tagged with the requester.
module au_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    au_arbiter_if.slave bus
);

    import au_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic               ptr;
    logic               grant_id;
    logic               id_q;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   au_c;
    flags_t             au_flags;
    logic [WIDTH-1:0]   c_q;
    flags_t             flags_q;
    logic               rsp_id_q;

    au u_au (
        .a     (op_a),
        .b     (op_b),
        .c     (au_c),
        .flags (au_flags)
    );

    // A lone request wins outright; a tie goes to the priority pointer
    always_comb begin
        grant_id = ptr;
        case (bus.req)
            2'b01:   grant_id = ID_REQ0;
            2'b10:   grant_id = ID_REQ1;
            default: grant_id = ptr;
        endcase
    end

    // State register; reset aborts any in-flight operation immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs, all derived from the current state
    always_comb begin
        state_nxt     = state;
        bus.ack       = 2'b00;
        bus.rsp_valid = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                bus.ack   = id_q ? 2'b10 : 2'b01;
                state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on grant, result capture after the add, and the
    // pointer handing priority to the other requester once consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= ID_REQ0;
            id_q     <= ID_REQ0;
            op_a     <= '0;
            op_b     <= '0;
            c_q      <= '0;
            flags_q  <= '0;
            rsp_id_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        id_q <= grant_id;
                        op_a <= grant_id ? bus.a1 : bus.a0;
                        op_b <= grant_id ? bus.b1 : bus.b0;
                    end
                end
                EXEC: begin
                    c_q      <= au_c;
                    flags_q  <= au_flags;
                    rsp_id_q <= id_q;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        ptr <= ~id_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.c      = c_q;
    assign bus.s      = flags_q.s;
    assign bus.zr     = flags_q.zr;
    assign bus.cy     = flags_q.cy;
    assign bus.p      = flags_q.p;
    assign bus.v      = flags_q.v;
    assign bus.rsp_id = rsp_id_q;

endmodule

// File: tb/tb_au_arbiter.sv
// Scoreboard bench for au_arbiter: drivers issue requests, a monitor
// predicts each grant and result from arithmetic rules and compares
// whenever the arbiter acknowledges or presents a response.
module tb_au_arbiter;

    typedef struct packed {
        logic        id;
        logic [15:0] c;
        logic        s;
        logic        zr;
        logic        cy;
        logic        p;
        logic        v;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        req0;
    logic        req1;
    logic        rsp_ready;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] b1;

    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t exp_q[$];
    logic rand_done;

    au_arbiter_if bus();

    assign bus.req       = {req1, req0};
    assign bus.a0        = a0;
    assign bus.b0        = b0;
    assign bus.a1        = a1;
    assign bus.b1        = b1;
    assign bus.rsp_ready = rsp_ready;

    au_arbiter #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic rsp_t mkRsp(logic id, logic [15:0] c, logic s, logic zr, logic cy, logic p, logic v);
        rsp_t r;
        r.id = id; r.c = c; r.s = s; r.zr = zr; r.cy = cy; r.p = p; r.v = v;
        return r;
    endfunction

    // Reference result from plain integer arithmetic on the operands
    function automatic rsp_t calcRsp(logic id, logic [15:0] a, logic [15:0] b);
        rsp_t        r;
        int unsigned usum;
        int          ssum;
        usum = 32'(a) + 32'(b);
        ssum = int'($signed(a)) + int'($signed(b));
        r.id = id;
        r.c  = usum[15:0];
        r.cy = (usum > 32'hFFFF);
        r.s  = (usum[15:0] >= 16'h8000);
        r.zr = (usum[15:0] == 16'h0000);
        r.p  = (($countones(usum[15:0]) % 2) == 0);
        r.v  = (ssum > 32767) || (ssum < -32768);
        return r;
    endfunction

    function automatic rsp_t packOut();
        return mkRsp(bus.rsp_id, bus.c, bus.s, bus.zr, bus.cy, bus.p, bus.v);
    endfunction

    function automatic logic [15:0] rndOperand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic setReq(input logic id, input logic val);
        if (id) req1 = val;
        else    req0 = val;
    endtask

    task automatic setOps(input logic id, input logic [15:0] a, input logic [15:0] b);
        if (id) begin a1 = a; b1 = b; end
        else    begin a0 = a; b0 = b; end
    endtask

    task automatic waitAck(input logic id, output int lat, output logic seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.ack[id] === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic id, input logic [15:0] a, input logic [15:0] b, output int lat);
        logic seen;
        @(posedge clk); #1;
        setOps(id, a, b);
        setReq(id, 1'b1);
        waitAck(id, lat, seen);
        check("ack_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        setReq(id, 1'b0);
    endtask

    task automatic checkOutput(input string name, input rsp_t exp, output int lat);
        logic seen;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        check({name, "_valid"}, 64'(seen), 64'd1);
        if (seen) check(name, 64'(packOut()), 64'(exp));
    endtask

    task automatic randDriver(input logic id, input int nops);
        int   gap;
        int   lat;
        logic seen;
        for (int k = 0; k < nops; k++) begin
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                @(posedge clk); #1;
                setReq(id, 1'b0);
                repeat (gap - 1) @(posedge clk);
            end
            @(posedge clk); #1;
            setOps(id, rndOperand(), rndOperand());
            setReq(id, 1'b1);
            waitAck(id, lat, seen);
            check("rand_ack_seen", 64'(seen), 64'd1);
        end
        @(posedge clk); #1;
        setReq(id, 1'b0);
    endtask

    // Monitor: predicts grants with a favoured-requester model, pushes the
    // expected result on each ack, and pops/compares on each handshake
    initial begin
        logic [1:0] prev_req;
        logic       favoured;
        logic       stall_prev;
        logic       gid;
        logic       exp_g;
        rsp_t       cur;
        rsp_t       held;
        rsp_t       exp;
        prev_req   = 2'b00;
        favoured   = 1'b0;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                exp_q.delete();
                favoured   = 1'b0;
                stall_prev = 1'b0;
                prev_req   = 2'b00;
            end else begin
                if (bus.ack !== 2'b00) begin
                    if (bus.ack !== 2'b01 && bus.ack !== 2'b10) begin
                        check("ack_onehot", 64'(bus.ack), 64'd1);
                    end else if (prev_req == 2'b00) begin
                        check("ack_unrequested", 64'(bus.ack), 64'd0);
                    end else begin
                        gid   = bus.ack[1];
                        exp_g = (prev_req == 2'b11) ? favoured : prev_req[1];
                        check("grant_order", 64'(gid), 64'(exp_g));
                        exp_q.push_back(calcRsp(gid, gid ? a1 : a0, gid ? b1 : b0));
                    end
                end
                cur = packOut();
                if (stall_prev) begin
                    check("rsp_hold", 64'({bus.rsp_valid, cur}), 64'({1'b1, held}));
                end
                if (bus.rsp_valid === 1'b1) begin
                    if (rsp_ready) begin
                        stall_prev = 1'b0;
                        if (exp_q.size() == 0) begin
                            check("rsp_unexpected", 64'(cur), 64'd0);
                        end else begin
                            exp = exp_q.pop_front();
                            check("scoreboard", 64'(cur), 64'(exp));
                            favoured = ~exp.id;
                        end
                    end else begin
                        stall_prev = 1'b1;
                        held       = cur;
                    end
                end else begin
                    stall_prev = 1'b0;
                end
                prev_req = bus.req;
            end
        end
    end

    // Directed scenarios followed by a randomized two-requester run
    initial begin
        int   lat;
        int   cnt;
        logic seen;
        logic first_id;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        rand_done = 1'b0;

        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("reset_outputs",
              64'({bus.ack, bus.rsp_valid, bus.rsp_id, bus.c, bus.s, bus.zr, bus.cy, bus.p, bus.v, bus.busy}),
              64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;

        applyStimulus(1'b0, 16'h8FFF, 16'h8000, lat);
        check("ack_latency", 64'(lat), 64'd2);
        checkOutput("add_carry_ovf", mkRsp(1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), lat);
        check("rsp_latency", 64'(lat), 64'd1);

        applyStimulus(1'b1, 16'hFFFE, 16'h0002, lat);
        checkOutput("add_zero", mkRsp(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0), lat);

        @(posedge clk); #1;
        a0 = 16'hAAAA; b0 = 16'h5555; a1 = 16'h0001; b1 = 16'h0001;
        req0 = 1'b1; req1 = 1'b1;
        checkOutput("alt_first",  mkRsp(1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), lat);
        checkOutput("alt_second", mkRsp(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), lat);
        checkOutput("alt_third",  mkRsp(1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), lat);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;

        @(posedge clk); #1;
        rsp_ready = 1'b0;
        a0 = 16'h1234; b0 = 16'h4321; a1 = 16'h7FFF; b1 = 16'h0001;
        req0 = 1'b1; req1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.ack !== 2'b00) seen = 1'b1;
        end
        first_id = bus.ack[1];
        check("stall_first_grant", 64'({seen, first_id}), 64'({1'b1, 1'b1}));
        @(posedge clk); #1;
        req1 = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_state", 64'({bus.busy, bus.rsp_valid, bus.ack}), 64'({1'b1, 1'b1, 2'b00}));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        waitAck(1'b0, lat, seen);
        check("grant_after_stall", 64'(seen), 64'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        repeat (4) @(posedge clk);

        #1;
        a0 = 16'h0101; b0 = 16'h0202;
        req0 = 1'b1;
        waitAck(1'b0, lat, seen);
        check("abort_ack_seen", 64'(seen), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("reset_in_exec", 64'({bus.ack, bus.rsp_valid, bus.busy}), 64'd0);
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) cnt++;
        end
        check("no_rsp_after_abort", 64'(cnt), 64'd0);

        @(posedge clk); #1;
        a0 = 16'h0F0F; b0 = 16'h00F1; a1 = 16'h8000; b1 = 16'h8000;
        req0 = 1'b1; req1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.ack !== 2'b00) seen = 1'b1;
        end
        check("ptr_after_reset", 64'(bus.ack), 64'(2'b01));
        @(posedge clk); #1;
        req0 = 1'b0;
        waitAck(1'b1, lat, seen);
        check("second_after_reset", 64'(seen), 64'd1);
        @(posedge clk); #1;
        req1 = 1'b0;
        repeat (4) @(posedge clk);

        fork
            begin
                fork
                    randDriver(1'b0, 30);
                    randDriver(1'b1, 30);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join

        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
